// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// ---------------------------------------------------------------------------
// Shares one 8N1 UART transmitter between NUM_CLIENTS byte-stream sources.
// Grants are round-robin at message granularity. A grant is held until the
// owner's last byte, or until MAX_BURST bytes have gone out; after that the
// owner competes again and continues its message on its next grant.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high; aborts any transfer in flight
//   req_valid    per-client byte available
//   req_data     per-client byte, client i at [8i+7:8i]
//   req_last     per-client final-byte marker
//   req_ready    per-client byte accepted this cycle (combinational)
//   tx_data_out  byte to the transmitter data_in (registered)
//   tx_send      one-cycle send pulse to the transmitter (registered)
//   tx_busy      transmitter busy
//   grant        one-hot current owner, zero when idle (registered)
//   active       high whenever the arbiter is not idle
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_CLIENTS = 4,
    parameter int MAX_BURST   = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CLIENTS-1:0]     req_valid,
    input  logic [8*NUM_CLIENTS-1:0]   req_data,
    input  logic [NUM_CLIENTS-1:0]     req_last,
    output logic [NUM_CLIENTS-1:0]     req_ready,
    output logic [7:0]                 tx_data_out,
    output logic                       tx_send,
    input  logic                       tx_busy,
    output logic [NUM_CLIENTS-1:0]     grant,
    output logic                       active
);

    localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam logic [NUM_CLIENTS-1:0] ONE_HOT0 = NUM_CLIENTS'(1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

    state_t           state;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W-1:0] last_grant;
    logic [7:0]       burst_cnt;
    logic             last_flag;

    // Round-robin search starting just after the previous owner.
    // Returns {found, index}.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_CLIENTS-1:0] v,
                                               input logic [IDX_W-1:0] last);
        logic             found;
        logic [IDX_W-1:0] idx;
        int               c;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_CLIENTS; k++) begin
            c = (int'(last) + k) % NUM_CLIENTS;
            if (!found && v[c]) begin
                found = 1'b1;
                idx   = IDX_W'(c);
            end
        end
        return {found, idx};
    endfunction

    // Burst counter holds at MAX_BURST rather than wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'(MAX_BURST)) ? c : c + 8'd1;
    endfunction

    logic [IDX_W:0]   pick;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             sel_valid;
    logic             sel_last;
    logic [7:0]       sel_data;
    logic             xfer;

    always_comb begin
        pick       = rr_pick(req_valid, last_grant);
        pick_found = pick[IDX_W];
        pick_idx   = pick[IDX_W-1:0];
        sel_valid  = req_valid[gnt_idx];
        sel_last   = req_last[gnt_idx];
        sel_data   = req_data[8*gnt_idx +: 8];
        xfer       = sel_valid && (state == SEND) && !tx_busy;
    end

    // Ready is gated by busy so a byte is never accepted while the
    // transmitter is still shifting the previous one.
    always_comb begin
        req_ready = '0;
        if (state == SEND && !tx_busy)
            req_ready = grant;
    end

    assign active = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= '0;
            gnt_idx     <= '0;
            tx_send     <= 1'b0;
            tx_data_out <= 8'h00;
            burst_cnt   <= 8'h00;
            last_flag   <= 1'b0;
            last_grant  <= IDX_W'(NUM_CLIENTS - 1);
        end else begin
            tx_send <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        gnt_idx   <= pick_idx;
                        grant     <= ONE_HOT0 << pick_idx;
                        burst_cnt <= 8'h00;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        tx_data_out <= sel_data;
                        tx_send     <= 1'b1;
                        last_flag   <= sel_last;
                        burst_cnt   <= sat_inc(burst_cnt);
                        state       <= WAIT_HI;
                    end
                end
                // The transmitter raises busy one cycle after send.
                WAIT_HI: begin
                    if (tx_busy)
                        state <= WAIT_LO;
                end
                WAIT_LO: begin
                    if (!tx_busy) begin
                        if (last_flag || burst_cnt == 8'(MAX_BURST)) begin
                            last_grant <= gnt_idx;
                            grant      <= '0;
                            state      <= IDLE;
                        end else begin
                            state <= SEND;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    localparam int NC         = 4;
    localparam int MB         = 3;
    localparam int BIT_PERIOD = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [NC-1:0]   req_valid;
    logic [8*NC-1:0] req_data;
    logic [NC-1:0]   req_last;
    logic [NC-1:0]   req_ready;
    logic [7:0]      tx_data_out;
    logic            tx_send;
    logic            tx_busy = 1'b0;
    logic [NC-1:0]   grant;
    logic            active;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_CLIENTS(NC), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .tx_data_out(tx_data_out), .tx_send(tx_send),
        .tx_busy(tx_busy), .grant(grant), .active(active)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Client sources: each presents bytes base..base+len-1 of its table.
    logic [7:0] cl_d [NC][8];
    logic       cl_l [NC][8];
    int         cl_len  [NC];
    int         cl_base [NC];
    int         cl_cnt  [NC] = '{default: 0};
    logic       cl_hold [NC];

    always_comb begin
        int p;
        p         = 0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        for (int i = 0; i < NC; i++) begin
            p = cl_cnt[i] - cl_base[i];
            if (!cl_hold[i] && p < cl_len[i]) begin
                req_valid[i]        = 1'b1;
                req_data[8*i +: 8]  = cl_d[i][p];
                req_last[i]         = cl_l[i][p];
            end
        end
    end

    // Monitor: handshakes, send pulses, grant sequence.
    int            sends = 0;
    int            viol  = 0;
    logic [NC-1:0] glog [64];
    int            gn    = 0;
    logic [NC-1:0] prev_g = '0;

    always @(posedge clk) begin
        for (int i = 0; i < NC; i++)
            if (!reset && req_valid[i] && req_ready[i])
                cl_cnt[i] <= cl_cnt[i] + 1;
        if (tx_send) sends <= sends + 1;
        if (tx_send && tx_busy) viol <= viol + 1;
        prev_g <= grant;
        if (grant != '0 && grant != prev_g) begin
            glog[gn] <= grant;
            gn       <= gn + 1;
        end
    end

    // Transmitter model: 8N1, BIT_PERIOD cycles per bit, busy from the cycle after send.
    logic       tx_line = 1'b1;
    logic [9:0] frame   = '1;
    int         tick    = 0;
    int         bitidx  = 0;
    logic [7:0] blog [64];
    int         bn      = 0;

    always @(posedge clk) begin
        if (reset) begin
            tx_busy <= 1'b0;
            tx_line <= 1'b1;
            tick    <= 0;
            bitidx  <= 0;
        end else if (!tx_busy) begin
            if (tx_send) begin
                tx_busy  <= 1'b1;
                frame    <= {1'b1, tx_data_out, 1'b0};
                tx_line  <= 1'b0;
                tick     <= 0;
                bitidx   <= 0;
                blog[bn] <= tx_data_out;
                bn       <= bn + 1;
            end
        end else if (tick == BIT_PERIOD - 1) begin
            tick <= 0;
            if (bitidx == 9) begin
                tx_busy <= 1'b0;
                tx_line <= 1'b1;
            end else begin
                bitidx  <= bitidx + 1;
                tx_line <= frame[bitidx + 1];
            end
        end else begin
            tick <= tick + 1;
        end
    end

    task automatic set_byte(input int c, input int k, input logic [7:0] d, input logic l);
        cl_d[c][k] = d;
        cl_l[c][k] = l;
    endtask

    task automatic go(input int c, input int n);
        cl_base[c] = cl_cnt[c];
        cl_len[c]  = n;
    endtask

    task automatic wait_done(input string tag, input int budget);
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (!active && !tx_busy && req_valid == '0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_val({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    int         s, gs, ns;
    logic       found;
    logic [9:0] fr;
    logic [7:0] e2 [4] = '{8'h41, 8'h42, 8'h43, 8'h44};
    logic [7:0] e4 [6] = '{8'h01, 8'h02, 8'h03, 8'hAA, 8'h04, 8'h05};
    logic [7:0] e5 [4] = '{8'hB1, 8'hB2, 8'hB3, 8'hC3};

    initial begin
        reset = 1'b1;
        for (int i = 0; i < NC; i++) begin
            cl_len[i]  = 0;
            cl_base[i] = 0;
            cl_hold[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check_val("rst_grant", 32'(grant), 32'h0);
        check_val("rst_send", 32'(tx_send), 32'h0);
        check_val("rst_data", 32'(tx_data_out), 32'h0);
        check_val("rst_ready", 32'(req_ready), 32'h0);
        check_val("rst_active", 32'(active), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // 1: single byte, serial frame check
        ns = sends;
        set_byte(0, 0, 8'h55, 1'b1);
        go(0, 1);
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (tx_send) begin
                found = 1'b1;
                break;
            end
        end
        check_val("t1_send_seen", 32'(found), 32'h1);
        check_val("t1_grant", 32'(grant), 32'h1);
        check_val("t1_data", 32'(tx_data_out), 32'h55);
        repeat (2) @(negedge clk);
        fr[0] = tx_line;
        for (int k = 1; k < 10; k++) begin
            repeat (BIT_PERIOD) @(negedge clk);
            fr[k] = tx_line;
        end
        check_val("t1_start", 32'(fr[0]), 32'h0);
        check_val("t1_bits", 32'(fr[8:1]), 32'h55);
        check_val("t1_stop", 32'(fr[9]), 32'h1);
        wait_done("t1", 200);
        check_val("t1_grant_end", 32'(grant), 32'h0);
        check_val("t1_active_end", 32'(active), 32'h0);
        check_val("t1_sends", 32'(sends - ns), 32'd1);
        pulse_reset();

        // 2: simultaneous 2-byte messages from clients 0 and 2
        s = bn; gs = gn;
        set_byte(0, 0, 8'h41, 1'b0); set_byte(0, 1, 8'h42, 1'b1);
        set_byte(2, 0, 8'h43, 1'b0); set_byte(2, 1, 8'h44, 1'b1);
        go(0, 2); go(2, 2);
        wait_done("t2", 1000);
        check_val("t2_count", 32'(bn - s), 32'd4);
        for (int k = 0; k < 4; k++)
            check_val($sformatf("t2_byte%0d", k), 32'(blog[s + k]), 32'(e2[k]));
        check_val("t2_gcount", 32'(gn - gs), 32'd2);
        check_val("t2_g0", 32'(glog[gs]), 32'h1);
        check_val("t2_g1", 32'(glog[gs + 1]), 32'h4);

        // 3: last owner was 2, so client 3 goes before client 0
        s = bn; gs = gn;
        set_byte(0, 0, 8'h30, 1'b1);
        set_byte(3, 0, 8'h33, 1'b1);
        go(0, 1); go(3, 1);
        wait_done("t3", 1000);
        check_val("t3_byte0", 32'(blog[s]), 32'h33);
        check_val("t3_byte1", 32'(blog[s + 1]), 32'h30);
        check_val("t3_g0", 32'(glog[gs]), 32'h8);
        check_val("t3_g1", 32'(glog[gs + 1]), 32'h1);

        // 4: burst limit forces rotation mid-message
        s = bn; gs = gn;
        for (int k = 0; k < 5; k++) set_byte(1, k, 8'(k + 1), k == 4);
        set_byte(2, 0, 8'hAA, 1'b1);
        go(1, 5); go(2, 1);
        wait_done("t4", 2000);
        check_val("t4_count", 32'(bn - s), 32'd6);
        for (int k = 0; k < 6; k++)
            check_val($sformatf("t4_byte%0d", k), 32'(blog[s + k]), 32'(e4[k]));
        check_val("t4_g0", 32'(glog[gs]), 32'h2);
        check_val("t4_g1", 32'(glog[gs + 1]), 32'h4);
        check_val("t4_g2", 32'(glog[gs + 2]), 32'h2);

        // 5: owner stalls mid-message, waiting client must not preempt
        s = bn;
        set_byte(2, 0, 8'hB1, 1'b0); set_byte(2, 1, 8'hB2, 1'b0); set_byte(2, 2, 8'hB3, 1'b1);
        set_byte(3, 0, 8'hC3, 1'b1);
        go(2, 3); go(3, 1);
        found = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (cl_cnt[2] - cl_base[2] == 1) begin
                found = 1'b1;
                break;
            end
        end
        check_val("t5_first_accept", 32'(found), 32'h1);
        cl_hold[2] = 1'b1;
        repeat (60) @(negedge clk);
        ns = sends;
        repeat (100) @(negedge clk);
        check_val("t5_no_send", 32'(sends - ns), 32'd0);
        check_val("t5_grant_held", 32'(grant), 32'h4);
        check_val("t5_ready_held", 32'(req_ready), 32'h4);
        cl_hold[2] = 1'b0;
        wait_done("t5", 1000);
        check_val("t5_count", 32'(bn - s), 32'd4);
        for (int k = 0; k < 4; k++)
            check_val($sformatf("t5_byte%0d", k), 32'(blog[s + k]), 32'(e5[k]));

        // 6: reset while waiting for busy to fall
        set_byte(1, 0, 8'h61, 1'b0); set_byte(1, 1, 8'h62, 1'b0); set_byte(1, 2, 8'h63, 1'b0);
        go(1, 3);
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (tx_busy) begin
                found = 1'b1;
                break;
            end
        end
        check_val("t6_busy_seen", 32'(found), 32'h1);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_val("t6_grant", 32'(grant), 32'h0);
        check_val("t6_send", 32'(tx_send), 32'h0);
        check_val("t6_ready", 32'(req_ready), 32'h0);
        check_val("t6_active", 32'(active), 32'h0);
        go(1, 0);
        reset = 1'b0;
        @(negedge clk);
        s = bn; gs = gn;
        set_byte(0, 0, 8'h70, 1'b1);
        set_byte(1, 0, 8'h71, 1'b1);
        go(0, 1); go(1, 1);
        wait_done("t6", 1000);
        check_val("t6_g0", 32'(glog[gs]), 32'h1);
        check_val("t6_byte0", 32'(blog[s]), 32'h70);
        check_val("t6_byte1", 32'(blog[s + 1]), 32'h71);

        check_val("send_while_busy", 32'(viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares a single 8N1 UART transmitter between NUM_CLIENTS byte-stream requesters.
- Round-robin arbitration at message granularity: a grant is held until the client's last byte, or until MAX_BURST bytes have been sent.
- Drives the transmitter's data_in/send pair and paces itself on its busy output.
- Sits between on-chip message sources (status, debug dump, echo) and the transmitter instance feeding the TX pin.

Parameters:
NUM_CLIENTS, 4, number of requesters (2..8).
MAX_BURST, 16, maximum bytes per grant before forced rotation (1..255).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high
req_valid  input  NUM_CLIENTS  per-client byte available
req_data  input  8*NUM_CLIENTS  per-client byte; client i at bits [8i+7:8i]
req_last  input  NUM_CLIENTS  per-client marks final byte of a message
req_ready  output  NUM_CLIENTS  per-client byte accepted this cycle
tx_data_out  output  8  to transmitter data_in
tx_send  output  1  to transmitter send; one-cycle pulse
tx_busy  input  1  from transmitter busy
grant  output  NUM_CLIENTS  one-hot owner; all-zero when idle
active  output  1  high whenever state != IDLE

Behaviour:
- Reset: state=IDLE, grant=0, tx_send=0, tx_data_out=0, req_ready=0, burst_cnt=0, last_flag=0, last_grant=NUM_CLIENTS-1, so client 0 has first priority. Reset mid-frame aborts immediately; the transmitter is reset by the same signal.
- Registered outputs: tx_send, tx_data_out, grant. req_ready is combinational: grant[g] & (state==SEND) & ~tx_busy.
- Byte transfer occurs when req_valid[g] & req_ready[g].
- Client data must stay stable while valid is high and not yet accepted.
- State machine:
  - IDLE: if any req_valid, pick the first set bit scanning last_grant+1, last_grant+2, … with wrap-around modulo NUM_CLIENTS. Register grant one-hot, burst_cnt=0, go SEND. Arbitration takes 1 cycle.
  - SEND: if the transfer occurs, latch tx_data_out=req_data[g], pulse tx_send for exactly 1 cycle, last_flag=req_last[g], burst_cnt+=1, go WAIT_HI. If req_valid[g] is low, stay in SEND with the grant held; there is no timeout.
  - WAIT_HI: wait for tx_busy=1. The transmitter raises busy the cycle after send. Go WAIT_LO.
  - WAIT_LO: wait for tx_busy=0.
    - If last_flag or burst_cnt==MAX_BURST: last_grant=g, grant=0, go IDLE.
    - Otherwise go SEND.
- Exactly one tx_send per accepted byte; never assert tx_send while tx_busy=1.
- Bytes go out in acceptance order. Each client's bytes are contiguous within a grant.
- Simultaneous requests: round-robin order only. A newly raised req_valid never preempts an active grant.
- MAX_BURST reached without last: grant released. The client re-competes and resumes its message on its next grant.
- burst_cnt is 8 bits, saturates at MAX_BURST, and is cleared on every new grant.
- Inter-byte gap: 2 idle cycles between transmitter busy falling and the next send: WAIT_LO→SEND, then the SEND cycle.
- Inter-grant gap: 3 cycles. IDLE arbitration adds 1.

Test Plan:
1. Transmitter with BIT_PERIOD=4. Client 0 sends 0x55 with last=1 → one tx_send pulse, TX shows start bit, 10101010 LSB-first, stop bit; grant returns to 0; active drops after busy falls.
2. Clients 0 and 2 both present a 2-byte message ("AB" and "CD") in the same cycle → TX carries 0x41, 0x42, 0x43, 0x44 in that order; grant is 0001 then 0100.
3. After test 2 (last_grant=2), clients 0 and 3 request → client 3 is served first, then client 0.
4. MAX_BURST=3, client 1 streams 5 bytes 0x01..0x05 with last on 0x05 while client 2 holds a 1-byte 0xAA → TX order is 01 02 03 AA 04 05.
5. Granted client drops req_valid for 100 cycles mid-message while client 3 waits → no tx_send and grant unchanged; the message resumes when valid returns.
6. Assert reset during WAIT_LO of a burst → next cycle grant=0, tx_send=0, req_ready=0. After release, client 0 wins a simultaneous 0/1 request.
